// File: rtl/dmem_ctrl.sv
// Byte-addressed data memory with request/response handshake, 1-cycle registered response,
// post-reset array clear and range checks. Define DMEM_MISALIGN_ERR_EN to also reject misaligned accesses.
module dmem_ctrl #(
    parameter int DATA_W      = 64,
    parameter int DEPTH_BYTES = 1024,
    parameter int ADDR_W      = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              r_en_i,
    input  logic              w_en_i,
    input  logic [1:0]        size_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              ready_o,
    output logic              resp_valid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              dmem_error_o
);
    localparam int BYTES = DATA_W / 8;
    localparam int IDX_W = $clog2(DEPTH_BYTES);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_clr_ptr;
    logic [7:0]         r_mem [DEPTH_BYTES];
    logic               r_resp_valid;
    logic               r_err;
    logic [DATA_W-1:0]  r_rdata;

    logic               w_accept;
    logic               w_err;
    logic               w_misalign;
    logic               w_clr_last;
    logic [3:0]         w_nbytes;
    logic [ADDR_W:0]    w_end;
    logic [IDX_W-1:0]   w_idx;
    logic [BYTES-1:0]   w_mask;
    logic [DATA_W-1:0]  w_rdata;

    assign ready_o      = (r_state == ST_RUN);
    assign resp_valid_o = r_resp_valid;
    assign rdata_o      = r_rdata;
    assign dmem_error_o = r_err;

    assign w_accept   = req_i && ready_o;
    assign w_idx      = addr_i[IDX_W-1:0];
    assign w_clr_last = (r_clr_ptr == IDX_W'(DEPTH_BYTES - BYTES));
    // One extra bit on the end address keeps huge addresses from wrapping into range.
    assign w_end      = {1'b0, addr_i} + (ADDR_W+1)'(w_nbytes);

    always_comb begin
        w_nbytes = 4'd1;
        case (size_i)
            2'd0:    w_nbytes = 4'd1;
            2'd1:    w_nbytes = 4'd2;
            2'd2:    w_nbytes = 4'd4;
            2'd3:    w_nbytes = 4'd8;
            default: w_nbytes = 4'd1;
        endcase
    end

`ifdef DMEM_MISALIGN_ERR_EN
    assign w_misalign = ((addr_i[3:0] & (w_nbytes - 4'd1)) != 4'd0);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_err = (w_end > (ADDR_W+1)'(DEPTH_BYTES))
                || ({28'd0, w_nbytes} > 32'(BYTES))
                || (r_en_i == w_en_i)
                || w_misalign;

    always_comb begin
        w_mask  = '0;
        w_rdata = '0;
        for (int k = 0; k < BYTES; k++) begin
            w_mask[k] = ({28'd0, w_nbytes} > 32'(k));
            if (w_mask[k]) begin
                w_rdata[8*k +: 8] = r_mem[w_idx + IDX_W'(k)];
            end else begin
                w_rdata[8*k +: 8] = 8'd0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: begin
                if (w_clr_last) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_INIT;
                end
            end
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_INIT;
            r_clr_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) begin
                r_clr_ptr <= r_clr_ptr + IDX_W'(BYTES);
            end else begin
                r_clr_ptr <= r_clr_ptr;
            end
        end
    end

    // The array itself has no reset; INIT zeroes it one word per cycle instead.
    always_ff @(posedge clk_i) begin
        if (r_state == ST_INIT) begin
            for (int k = 0; k < BYTES; k++) begin
                r_mem[r_clr_ptr + IDX_W'(k)] <= 8'd0;
            end
        end else if (w_accept && w_en_i && !w_err) begin
            for (int k = 0; k < BYTES; k++) begin
                if (w_mask[k]) begin
                    r_mem[w_idx + IDX_W'(k)] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_resp_valid <= 1'b0;
            r_err        <= 1'b0;
            r_rdata      <= '0;
        end else begin
            r_resp_valid <= w_accept;
            if (w_accept) begin
                r_err   <= w_err;
                r_rdata <= (r_en_i && !w_err) ? w_rdata : '0;
            end else begin
                r_err   <= r_err;
                r_rdata <= r_rdata;
            end
        end
    end
endmodule
